pipemdu: RTL
============

# pipemdu

Iterative multiply/divide sequencer attached to the EXE stage of the 5-stage pipeline. It takes MULT/MULTU/DIV/DIVU operands from the EXE-stage register values and computes the result over 32 shift cycles. It owns the architectural HI/LO registers and generates the pipeline stall that holds IF/ID/EXE while a dependent or conflicting instruction reaches EXE. MTHI/MTLO writes and MFHI/MFLO reads are serviced here. The HI/LO read mux and pipeline freezing are external.

## Interface
Parameters: none. Width is fixed at 32.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- estart  in  1  EXE holds a MULT/MULTU/DIV/DIVU this cycle
- eop  in  2  00 multu, 01 mult, 10 divu, 11 div; sampled with estart
- ea, eb  in  32  rs / rt values in EXE
- emthi, emtlo  in  1  EXE holds MTHI / MTLO; value taken from ea
- emfhi, emflo  in  1  EXE holds MFHI / MFLO
- ecancel  in  1  EXE flush (exception/redirect); aborts any operation in flight
- busy  out  1  operation in flight
- stall  out  1  freeze IF/ID/EXE this cycle
- hi, lo  out  32  HI/LO register contents
- dz  out  1  last completed divide had divisor 0; held until the next accepted estart

## Operation
- States: IDLE, RUN, FIX. An iteration counter cnt (5 bits) and working registers are used: multiplicand/divisor magnitude, 64-bit product/remainder:quotient, sign flags sq (result sign) and sr (remainder sign), and isdiv.
- IDLE:
  - If estart and not ecancel: latch |ea| and |eb|. Signed ops take the magnitude; unsigned ops take the raw value. Set sq = sign(ea)^sign(eb) and sr = sign(ea), signed only. Clear cnt. Go to RUN.
  - Else, if emthi, HI <= ea. If emtlo, LO <= ea. Both may happen in the same cycle.
  - estart has priority over emthi/emtlo in the same cycle; the move is dropped.
- RUN, multiply: radix-2 shift-add. Each cycle, if the product LSB is 1, add the multiplicand to the upper 33 bits, then shift the 65-bit sum right by 1.
- RUN, divide: restoring. Each cycle, shift remainder:quotient left by 1. Trial-subtract the divisor from the upper 33 bits. If the result is non-negative, keep it and set quotient bit 0.
- cnt increments every RUN cycle. When cnt = 31, go to FIX.
- FIX:
  - Apply sign correction. Multiply: negate the 64-bit product if sq. Divide: negate the quotient if sq and the remainder if sr.
  - Write HI (product upper / remainder) and LO (product lower / quotient). Go to IDLE.
  - Divisor 0 overrides the result: LO <= 0xFFFFFFFF, HI <= original ea, dz <= 1. The operation still takes the full latency.
  - 0x80000000 div -1 gives LO = 0x80000000, HI = 0. This wraps; no trap.
- ecancel while busy: go to IDLE on the next edge. HI, LO and dz are unchanged. An estart in that same cycle is ignored.
- stall = busy & (estart | emthi | emtlo | emfhi | emflo). No queuing: a second mult/div waits in EXE until IDLE. stall is 0 in IDLE.
- Reset values: state IDLE, busy 0, stall 0, hi 0, lo 0, dz 0, cnt 0.

## Timing
- Accepting estart in cycle T means:
  - RUN in cycles T+1..T+32.
  - FIX in cycle T+33.
  - busy = 1 in cycles T+1..T+33.
  - New hi/lo visible from cycle T+34.
  - Latency is 34 cycles from issue to readable.
- A MFHI/MFLO arriving in any cycle T+1..T+33 is stalled. It proceeds in T+34 and reads the new value.
- A MTHI in cycle T+34 is not stalled and overwrites HI at the end of T+34.
- estart accepted in T+34 (back-to-back): the next result is visible at T+68.
- busy and stall are registered-state derived. They depend combinationally only on the current state and the E-stage strobes. There is no path from ea/eb to stall.

## Test plan
- multu ea=0xFFFFFFFF, eb=0xFFFFFFFF -> at T+34 HI=0xFFFFFFFE, LO=0x00000001; busy high T+1..T+33.
- mult ea=0xFFFFFFFD (-3), eb=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Separately, div ea=0xFFFFFFF9 (-7), eb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu ea=0x12345678, eb=0 -> LO=0xFFFFFFFF, HI=0x12345678, dz=1. Then divu 100/7 -> LO=14, HI=2, dz=0.
- div 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0. The next mult is held while busy: stall=1 every cycle from its arrival until IDLE, then accepted.
- mult 5×6 issued at T, emfhi asserted from T+1 -> stall=1 for T+1..T+33 and 0 at T+34 with HI=0, LO=30. An emtlo=0xAAAA5555 in IDLE -> LO=0xAAAA5555 next cycle.
- Set HI=0x11111111, LO=0x22222222, issue multu 3×3, assert ecancel at T+10 -> busy=0 at T+11, HI/LO unchanged. rst asserted mid-RUN -> next cycle state IDLE and hi=lo=0, dz=0.

Source files
------------

// File: rtl/pipemdu.sv
// pipemdu: iterative 32-bit multiply/divide unit for the EXE stage.
// Owns HI/LO, runs 32 shift cycles per MULT/MULTU/DIV/DIVU, applies the sign
// fix in a final cycle and stalls E-stage consumers while an operation is live.
module pipemdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        estart,
    input  logic [1:0]  eop,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic        emthi,
    input  logic        emtlo,
    input  logic        emfhi,
    input  logic        emflo,
    input  logic        ecancel,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mag_q, mag_d;          // |eb|: multiplicand or divisor
    logic [31:0] orig_a_q, orig_a_d;    // raw ea, returned in HI on divide-by-zero
    logic [64:0] acc_q, acc_d;          // product, or remainder:quotient
    logic        sq_q, sq_d;
    logic        sr_q, sr_d;
    logic        isdiv_q, isdiv_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        dz_q, dz_d;

    logic        accept;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [64:0] mul_step;
    logic [32:0] div_trial;
    logic [64:0] div_step;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign accept = (state_q == S_IDLE) && estart && !ecancel;

    // Signed ops iterate on magnitudes; unsigned ops pass the raw values
    assign abs_a = (eop[0] && ea[31]) ? -ea : ea;
    assign abs_b = (eop[0] && eb[31]) ? -eb : eb;

    // One radix-2 shift-add multiply step on the 65-bit accumulator
    assign mul_sum  = acc_q[64:32] + {1'b0, mag_q};
    assign mul_step = acc_q[0] ? {1'b0, mul_sum, acc_q[31:1]} : {1'b0, acc_q[64:1]};

    // One restoring divide step: shift left, trial-subtract from the upper 33 bits
    assign div_trial = acc_q[63:31] - {1'b0, mag_q};
    assign div_step  = div_trial[32] ? {acc_q[63:0], 1'b0}
                                     : {div_trial, acc_q[30:0], 1'b1};

    assign prod_fix = sq_q ? -acc_q[63:0] : acc_q[63:0];
    assign quo_fix  = sq_q ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = sr_q ? -acc_q[63:32] : acc_q[63:32];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a cancel returns to IDLE from RUN or FIX
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (ecancel) state_d = S_IDLE;
                     else if (cnt_q == 5'd31) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs derived from state and E-stage strobes only (no operand path)
    always_comb begin
        busy  = (state_q != S_IDLE);
        stall = busy && (estart || emthi || emtlo || emfhi || emflo);
    end

    // Datapath next-state: operand capture, iteration, result write-back, moves
    always_comb begin
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        orig_a_d = orig_a_q;
        acc_d    = acc_q;
        sq_d     = sq_q;
        sr_d     = sr_q;
        isdiv_d  = isdiv_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mag_d    = abs_b;
                    acc_d    = {33'd0, abs_a};
                    orig_a_d = ea;
                    sq_d     = eop[0] && (ea[31] ^ eb[31]);
                    sr_d     = eop[0] && ea[31];
                    isdiv_d  = eop[1];
                    cnt_d    = 5'd0;
                    dz_d     = 1'b0;
                end else begin
                    if (emthi) hi_d = ea;
                    if (emtlo) lo_d = ea;
                end
            end
            S_RUN: begin
                if (!ecancel) begin
                    acc_d = isdiv_q ? div_step : mul_step;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_FIX: begin
                if (!ecancel) begin
                    if (!isdiv_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (mag_q == 32'd0) begin
                        hi_d = orig_a_q;
                        lo_d = 32'hFFFF_FFFF;
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 5'd0;
            mag_q    <= 32'd0;
            orig_a_q <= 32'd0;
            acc_q    <= 65'd0;
            sq_q     <= 1'b0;
            sr_q     <= 1'b0;
            isdiv_q  <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            dz_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            orig_a_q <= orig_a_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            sr_q     <= sr_d;
            isdiv_q  <= isdiv_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign dz = dz_q;

endmodule
